map_writer: RTL and testbench

Owns the game's tile map and is its only writer. After reset or a new round it sweeps the grid into a FRAME border around an EMPTY interior. During play it stamps each player's trail into the map as their positions change. Its map output feeds the collision/movement controller and the VGA tile renderer; it consumes that controller's position and collision outputs.

---
 rtl/game_pkg.sv | 26 ++
 rtl/map_sweep_counter.sv | 56 +++++
 rtl/map_writer.sv | 164 ++++++++++++++++
 tb/tb_map_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_pkg: shared tile map types, dimensions and FSM encodings       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package game_pkg;

  localparam int MAP_WIDTH  = 40;
  localparam int MAP_HEIGHT = 30;

  localparam logic [7:0] start_x_1 = 8'd5;
  localparam logic [7:0] start_y_1 = 8'd5;
  localparam logic [7:0] start_x_2 = 8'd34;
  localparam logic [7:0] start_y_2 = 8'd24;

  typedef enum logic [1:0] {EMPTY, FRAME, PLAYER1, PLAYER2} tile;

  typedef enum logic [1:0] {CLEAR, ARMED, RUN, FROZEN} map_wr_state;

  // Modes 01 and 11 are rounds in play; 00 and 10 both mean idle.
  function automatic logic player_active(input logic [1:0] sel);
    return sel[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_sweep_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | map_sweep_counter: raster x/y index for the map clear sweep         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module map_sweep_counter #(
  parameter int W = 8,
  parameter int H = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  output logic [$clog2(W)-1:0] x,
  output logic [$clog2(H)-1:0] y,
  output logic                 done
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (x_q == XW'(W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(H - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign done = (x_q == XW'(W - 1)) && (y_q == YW'(H - 1));

endmodule
`default_nettype wire

// File: rtl/map_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | map_writer: sole writer of the tile map (clear sweep + trails)      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module map_writer
  import game_pkg::*;
#(
  parameter int W = MAP_WIDTH,
  parameter int H = MAP_HEIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] selected_player,
  input  logic [7:0] current_x_1,
  input  logic [7:0] current_y_1,
  input  logic [7:0] current_x_2,
  input  logic [7:0] current_y_2,
  input  logic       player1_collision,
  input  logic       player2_collision,
  output tile        map [W][H],
  output logic       clearing,
  output logic       round_over
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  map_wr_state   state_q, state_d;
  logic [7:0]    last_x_1_q, last_x_1_d, last_y_1_q, last_y_1_d;
  logic [7:0]    last_x_2_q, last_x_2_d, last_y_2_q, last_y_2_d;
  logic          req_1, req_2, sweep_we;
  logic          wr_1, wr_2, wr_sweep;
  logic          sweep_start, sweep_step, sweep_done;
  logic [XW-1:0] sweep_x;
  logic [YW-1:0] sweep_y;
  logic          active;

  assign active = player_active(selected_player);

  map_sweep_counter #(.W(W), .H(H)) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .start (sweep_start),
    .step  (sweep_step),
    .x     (sweep_x),
    .y     (sweep_y),
    .done  (sweep_done)
  );

  always_comb begin
    state_d     = state_q;
    last_x_1_d  = last_x_1_q;
    last_y_1_d  = last_y_1_q;
    last_x_2_d  = last_x_2_q;
    last_y_2_d  = last_y_2_q;
    req_1       = 1'b0;
    req_2       = 1'b0;
    sweep_we    = 1'b0;
    sweep_start = 1'b0;
    sweep_step  = 1'b0;
    case (state_q)
      CLEAR: begin
        sweep_we   = 1'b1;
        sweep_step = 1'b1;
        if (sweep_done) state_d = ARMED;
      end
      ARMED: begin
        if (active) begin
          state_d    = RUN;
          req_1      = 1'b1;
          req_2      = 1'b1;
          last_x_1_d = current_x_1;
          last_y_1_d = current_y_1;
          last_x_2_d = current_x_2;
          last_y_2_d = current_y_2;
        end
      end
      RUN: begin
        if (!active) begin
          state_d     = CLEAR;
          sweep_start = 1'b1;
        end else begin
          if ((current_x_1 != last_x_1_q) || (current_y_1 != last_y_1_q)) begin
            req_1      = 1'b1;
            last_x_1_d = current_x_1;
            last_y_1_d = current_y_1;
          end
          if ((current_x_2 != last_x_2_q) || (current_y_2 != last_y_2_q)) begin
            req_2      = 1'b1;
            last_x_2_d = current_x_2;
            last_y_2_d = current_y_2;
          end
          if (player1_collision || player2_collision) state_d = FROZEN;
        end
      end
      FROZEN: begin
        if (!active) begin
          state_d     = CLEAR;
          sweep_start = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      last_x_1_q <= '0;
      last_y_1_q <= '0;
      last_x_2_q <= '0;
      last_y_2_q <= '0;
    end else begin
      state_q    <= state_d;
      last_x_1_q <= last_x_1_d;
      last_y_1_q <= last_y_1_d;
      last_x_2_q <= last_x_2_d;
      last_y_2_q <= last_y_2_d;
    end
  end

  // Cells carry no reset, so reset must also block any write on its edge.
  assign wr_1     = req_1 & ~rst;
  assign wr_2     = req_2 & ~rst;
  assign wr_sweep = sweep_we & ~rst;

  assign clearing   = (state_q == CLEAR);
  assign round_over = (state_q == FROZEN);

  // Each cell decodes both players itself; an out-of-range coordinate
  // simply matches no cell, and a FRAME cell refuses player writes.
  for (genvar gx = 0; gx < W; gx++) begin : g_col
    for (genvar gy = 0; gy < H; gy++) begin : g_cell
      localparam tile SWEEP_TILE =
        ((gx == 0) || (gx == W - 1) || (gy == 0) || (gy == H - 1)) ? FRAME : EMPTY;

      tile  cell_q, cell_d;
      logic hit_1, hit_2, hit_sweep;

      assign hit_1     = (current_x_1 == 8'(gx)) && (current_y_1 == 8'(gy));
      assign hit_2     = (current_x_2 == 8'(gx)) && (current_y_2 == 8'(gy));
      assign hit_sweep = (sweep_x == XW'(gx)) && (sweep_y == YW'(gy));

      always_comb begin
        cell_d = cell_q;
        if (wr_sweep && hit_sweep) begin
          cell_d = SWEEP_TILE;
        end else if (cell_q != FRAME) begin
          if (wr_1 && hit_1)      cell_d = PLAYER1;
          else if (wr_2 && hit_2) cell_d = PLAYER2;
        end
      end

      always_ff @(posedge clk) begin
        cell_q <= cell_d;
      end

      assign map[gx][gy] = cell_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_map_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_map_writer: directed scoreboard bench for map_writer (8x6 map)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_map_writer;
  import game_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic [7:0] x1, y1, x2, y2;
  logic       c1, c2;
  tile        map_o [W][H];
  logic       clearing, round_over;

  map_writer #(.W(W), .H(H)) dut (
    .clk               (clk),
    .rst               (rst),
    .selected_player   (sel),
    .current_x_1       (x1),
    .current_y_1       (y1),
    .current_x_2       (x2),
    .current_y_2       (y2),
    .player1_collision (c1),
    .player2_collision (c2),
    .map               (map_o),
    .clearing          (clearing),
    .round_over        (round_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    x;
    int    y;
    tile   t;
  } exp_t;

  exp_t exp_q[$];
  tile  mdl [W][H];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_cell(input string tag, input int x, input int y, input tile t);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.t = t;
    exp_q.push_back(e);
    mdl[x][y] = t;
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (map_o[e.x][e.y] === e.t) else begin
        n_fail++;
        $error("FAIL %s: map[%0d][%0d] observed %0d expected %0d",
               e.tag, e.x, e.y, map_o[e.x][e.y], e.t);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int x = 0; x < W; x++) begin
      for (int y = 0; y < H; y++) begin
        n_assert++;
        assert (map_o[x][y] === mdl[x][y]) else begin
          n_fail++;
          $error("FAIL %s: map[%0d][%0d] observed %0d expected %0d",
                 tag, x, y, map_o[x][y], mdl[x][y]);
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mdl[x][y] = (x == 0 || x == W - 1 || y == 0 || y == H - 1) ? FRAME : EMPTY;
  endtask

  // Counts consecutive sampled cycles with clearing high, bounded.
  task automatic count_sweep(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!clearing) break;
      n++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; sel = 2'b00; c1 = 1'b0; c2 = 1'b0;
    x1 = 8'd0; y1 = 8'd0; x2 = 8'd0; y2 = 8'd0;

    // Reset sweep
    step();
    chk_int("rst_clearing", int'(clearing), 1);
    chk_int("rst_round_over", int'(round_over), 0);
    step();
    step();
    rst = 1'b0;
    count_sweep(cnt);
    chk_int("sweep_len", cnt, 48);
    model_clear();
    expect_cell("border_left", 0, 3, FRAME);
    expect_cell("border_corner", 7, 5, FRAME);
    expect_cell("interior", 3, 3, EMPTY);
    drain();
    check_all("after_sweep");
    chk_int("state_armed", int'(dut.state_q), int'(ARMED));

    // Start and trail
    x1 = 8'd2; y1 = 8'd2; x2 = 8'd5; y2 = 8'd3; sel = 2'b01;
    step();
    expect_cell("start_p1", 2, 2, PLAYER1);
    expect_cell("start_p2", 5, 3, PLAYER2);
    drain();
    check_all("after_start");
    x1 = 8'd3;
    step();
    expect_cell("trail_p1", 3, 2, PLAYER1);
    expect_cell("trail_keep", 2, 2, PLAYER1);
    drain();

    // Frame protection and range
    x2 = 8'd0; y2 = 8'd3;
    step();
    expect_cell("frame_kept", 0, 3, FRAME);
    drain();
    x2 = 8'd9; y2 = 8'd1;
    step();
    check_all("out_of_range");
    x1 = 8'd4; y1 = 8'd4; x2 = 8'd4; y2 = 8'd4;
    step();
    expect_cell("same_cell_p1_wins", 4, 4, PLAYER1);
    drain();
    check_all("after_same_cell");

    // Collision freeze
    c1 = 1'b1;
    step();
    c1 = 1'b0;
    chk_int("round_over_rise", int'(round_over), 1);
    chk_int("frozen_clearing", int'(clearing), 0);
    x1 = 8'd1; y1 = 8'd1; x2 = 8'd2; y2 = 8'd3;
    step();
    x1 = 8'd1; y1 = 8'd2;
    step();
    check_all("frozen_hold");
    chk_int("round_over_hold", int'(round_over), 1);

    // New round
    sel = 2'b00;
    step();
    chk_int("new_round_clearing", int'(clearing), 1);
    chk_int("new_round_round_over", int'(round_over), 0);
    count_sweep(cnt);
    chk_int("new_round_sweep_len", cnt, 48);
    model_clear();
    expect_cell("trail_gone", 3, 2, EMPTY);
    expect_cell("tie_gone", 4, 4, EMPTY);
    drain();
    check_all("new_round_map");

    // Reset in the middle of a sweep
    sel = 2'b01;
    step();
    expect_cell("restart_p1", 1, 2, PLAYER1);
    expect_cell("restart_p2", 2, 3, PLAYER2);
    drain();
    sel = 2'b00;
    step();
    repeat (20) step();
    chk_int("mid_sweep_clearing", int'(clearing), 1);
    rst = 1'b1;
    step();
    chk_int("mid_rst_clearing", int'(clearing), 1);
    rst = 1'b0;
    count_sweep(cnt);
    chk_int("mid_rst_sweep_len", cnt, 48);
    model_clear();
    check_all("mid_rst_map");
    chk_int("final_state_armed", int'(dut.state_q), int'(ARMED));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
